// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives Moore-style datapath strobes from the state plus the instruction
// fields latched in DECODE. Tracks a sticky halt flag and a retire counter.
module multicycle_control_fsm #(
    parameter int MEM_WAIT     = 0,
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opc,
    input  logic [5:0]       func,
    output logic             RegDest,
    output logic             RegisterWrite,
    output logic             ALUSource,
    output logic             ALUSource2,
    output logic             RegSel,
    output logic             WriteMem,
    output logic             ReadMem,
    output logic             MemToReg,
    output logic             Branch,
    output logic [3:0]       operation,
    output logic             pc_write,
    output logic             ir_write,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef struct packed {
        logic       legal;
        logic       r_type;
        logic       shift;
        logic       lw;
        logic       sw;
        logic       beq;
        logic [3:0] op;
    } dec_t;

    // Instruction class decode; anything unrecognised comes back all-zero.
    function automatic dec_t decode(input logic [5:0] o, input logic [5:0] f);
        dec_t d;
        d = '0;
        case (o)
            6'h00: begin
                d.legal  = 1'b1;
                d.r_type = 1'b1;
                case (f)
                    6'h20:   d.op = OP_ADD;
                    6'h22:   d.op = OP_SUB;
                    6'h24:   d.op = OP_AND;
                    6'h25:   d.op = OP_OR;
                    6'h2A:   d.op = OP_SLT;
                    6'h00:   begin d.op = OP_SLL; d.shift = 1'b1; end
                    6'h02:   begin d.op = OP_SRL; d.shift = 1'b1; end
                    default: d.legal = 1'b0;
                endcase
            end
            6'h23:   begin d.legal = 1'b1; d.lw  = 1'b1; d.op = OP_ADD; end
            6'h2B:   begin d.legal = 1'b1; d.sw  = 1'b1; d.op = OP_ADD; end
            6'h04:   begin d.legal = 1'b1; d.beq = 1'b1; d.op = OP_SUB; end
            6'h08:   begin d.legal = 1'b1; d.op = OP_ADD; end
            default: d.legal = 1'b0;
        endcase
        if (!d.legal) d = '0;
        return d;
    endfunction

    function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
        dec_t d;
        d = decode(o, f);
        return d.legal;
    endfunction

    logic [5:0] opc_q, func_q;
    logic [3:0] wait_cnt;
    dec_t       dec_q;
    logic       in_legal;

    assign dec_q    = decode(opc_q, func_q);
    assign in_legal = is_legal(opc, func);

    // State sequencing, instruction latch, MEM wait counter, halt and retire count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            opc_q    <= '0;
            func_q   <= '0;
            wait_cnt <= '0;
            halted   <= 1'b0;
            retired  <= '0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    opc_q  <= opc;
                    func_q <= func;
                    if (in_legal) begin
                        state <= S_EXEC;
                    end else if (ILLEGAL_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_EXEC: begin
                    if (dec_q.beq) begin
                        state <= S_FETCH;
                    end else if (dec_q.lw || dec_q.sw) begin
                        state    <= S_MEM;
                        wait_cnt <= 4'(MEM_WAIT);
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                    else                  state    <= dec_q.lw ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
            if (pc_write) retired <= retired + CNT_W'(1);
        end
    end

    // Moore strobes; ALU mux selects stay put from EXEC to the end of the
    // instruction so the address/result path is stable through MEM and WB.
    always_comb begin
        RegDest       = 1'b0;
        RegisterWrite = 1'b0;
        ALUSource     = 1'b0;
        ALUSource2    = 1'b0;
        RegSel        = 1'b0;
        WriteMem      = 1'b0;
        ReadMem       = 1'b0;
        MemToReg      = 1'b0;
        Branch        = 1'b0;
        operation     = 4'b0000;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        if (rst) begin
            if (state == S_EXEC || state == S_MEM || state == S_WB) begin
                RegDest    = dec_q.r_type;
                ALUSource  = dec_q.r_type | dec_q.beq;
                ALUSource2 = dec_q.shift;
                RegSel     = dec_q.shift;
                operation  = dec_q.op;
            end
            case (state)
                S_FETCH: ir_write = 1'b1;
                S_EXEC: begin
                    Branch   = dec_q.beq;
                    pc_write = dec_q.beq;
                end
                S_MEM: begin
                    ReadMem  = dec_q.lw;
                    WriteMem = dec_q.sw;
                    pc_write = dec_q.sw && (wait_cnt == 4'd0);
                end
                S_WB: begin
                    // an illegal instruction in NOP mode decodes to all-zero, so no write
                    RegisterWrite = dec_q.legal;
                    ReadMem       = dec_q.lw;
                    MemToReg      = dec_q.lw;
                    pc_write      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: three independently driven instances
// (different MEM_WAIT / illegal handling / counter width). Stimulus pushes the
// expected per-cycle output vectors of each instruction into a per-lane queue;
// a negedge monitor pops and compares every cycle.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic        reg_dest, reg_write, alu_src, alu_src2, reg_sel;
        logic        wmem, rmem, mem2reg, branch;
        logic [3:0]  op;
        logic        pc_write, ir_write, halted;
        logic [2:0]  state;
        logic [31:0] retired;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_l  [3];
    logic [5:0] opc_l  [3];
    logic [5:0] func_l [3];
    out_t       obs    [3];

    out_t        exp_q  [3][$];
    logic [31:0] mcount [3];
    int          n_chk = 0;
    int          n_fail = 0;

    logic [5:0] rfun [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};

    always #5 clk = ~clk;

    // lane 0: MEM_WAIT=3, halt on illegal, 4-bit counter (wraps quickly)
    // lane 1: MEM_WAIT=0, illegal retires as NOP, 32-bit counter
    // lane 2: MEM_WAIT=2, halt on illegal, 32-bit counter
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MW = (g == 0) ? 3 : ((g == 1) ? 0 : 2);
        localparam bit IH = (g == 1) ? 1'b0 : 1'b1;
        localparam int CW = (g == 0) ? 4 : 32;
        logic rd, rw, as1, as2, rs, wm, rm, m2r, br, pcw, irw, hl;
        logic [3:0]    op;
        logic [2:0]    st;
        logic [CW-1:0] ret;
        multicycle_control_fsm #(.MEM_WAIT(MW), .ILLEGAL_HALT(IH), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(rst_l[g]), .opc(opc_l[g]), .func(func_l[g]),
            .RegDest(rd), .RegisterWrite(rw), .ALUSource(as1), .ALUSource2(as2),
            .RegSel(rs), .WriteMem(wm), .ReadMem(rm), .MemToReg(m2r), .Branch(br),
            .operation(op), .pc_write(pcw), .ir_write(irw), .halted(hl),
            .state(st), .retired(ret)
        );
        assign obs[g] = {rd, rw, as1, as2, rs, wm, rm, m2r, br, op, pcw, irw, hl, st, 32'(ret)};
    end

    task automatic chk(input string name, input int g, input out_t got, input out_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t: got %h expected %h", name, g, $time, got, exp);
        end
    endtask

    // Monitor: one expected vector per cycle whenever the lane has one queued.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (exp_q[g].size() > 0) begin
                out_t e;
                e = exp_q[g].pop_front();
                chk("cycle", g, obs[g], e);
            end
        end
    end

    function automatic out_t blank(input int g);
        out_t v;
        v = '0;
        v.retired = (g == 0) ? (mcount[g] & 32'hF) : mcount[g];
        return v;
    endfunction

    // Reference model: expected output trace of one instruction from FETCH on.
    task automatic issue(input int g, input logic [5:0] o, input logic [5:0] f, output int n);
        int   mw;
        bit   legal, r, sh, lw, sw, beq;
        logic [3:0] aop;
        out_t v, m;
        mw = (g == 0) ? 3 : ((g == 1) ? 0 : 2);
        legal = 1; r = 0; sh = 0; lw = 0; sw = 0; beq = 0; aop = 4'b0010;
        case (o)
            6'h00: begin
                r = 1;
                case (f)
                    6'h20: aop = 4'b0010;
                    6'h22: aop = 4'b0110;
                    6'h24: aop = 4'b0000;
                    6'h25: aop = 4'b0001;
                    6'h2A: aop = 4'b0111;
                    6'h00: begin aop = 4'b0011; sh = 1; end
                    6'h02: begin aop = 4'b0100; sh = 1; end
                    default: legal = 0;
                endcase
            end
            6'h23: lw = 1;
            6'h2B: sw = 1;
            6'h04: begin beq = 1; aop = 4'b0110; end
            6'h08: ;
            default: legal = 0;
        endcase
        n = 0;
        v = blank(g); v.ir_write = 1;           exp_q[g].push_back(v); n++;
        v = blank(g); v.state = 3'd1;           exp_q[g].push_back(v); n++;
        if (!legal) begin
            if (g != 1) begin
                repeat (100) begin
                    v = blank(g); v.state = 3'd7; v.halted = 1;
                    exp_q[g].push_back(v); n++;
                end
            end else begin
                v = blank(g); v.state = 3'd4; v.pc_write = 1;
                exp_q[g].push_back(v); n++; mcount[g]++;
            end
            return;
        end
        m = '0;
        m.reg_dest = r; m.alu_src = r | beq; m.alu_src2 = sh; m.reg_sel = sh; m.op = aop;
        v = blank(g) | m; v.state = 3'd2;
        if (beq) begin
            v.branch = 1; v.pc_write = 1;
            exp_q[g].push_back(v); n++; mcount[g]++;
            return;
        end
        exp_q[g].push_back(v); n++;
        if (lw || sw) begin
            for (int k = 0; k <= mw; k++) begin
                v = blank(g) | m; v.state = 3'd3; v.rmem = lw; v.wmem = sw;
                v.pc_write = sw && (k == mw);
                exp_q[g].push_back(v); n++;
                if (v.pc_write) mcount[g]++;
            end
            if (sw) return;
        end
        v = blank(g) | m; v.state = 3'd4; v.reg_write = 1; v.rmem = lw; v.mem2reg = lw;
        v.pc_write = 1;
        exp_q[g].push_back(v); n++; mcount[g]++;
    endtask

    // Called just after a rising edge with the lane in FETCH; returns likewise.
    task automatic run_instr(input int g, input logic [5:0] o, input logic [5:0] f);
        int n;
        opc_l[g] = o; func_l[g] = f;
        issue(g, o, f, n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin  // instruction latched; later input changes must be ignored
                opc_l[g]  = 6'($urandom);
                func_l[g] = 6'($urandom);
            end
        end
    endtask

    task automatic run_rand(input int g, input bit allow_ill);
        int k;
        logic [5:0] o, f;
        k = $urandom_range(0, allow_ill ? 12 : 10);
        f = 6'($urandom);
        if (k <= 6)       begin o = 6'h00; f = rfun[k]; end
        else if (k == 7)  o = 6'h23;
        else if (k == 8)  o = 6'h2B;
        else if (k == 9)  o = 6'h04;
        else if (k == 10) o = 6'h08;
        else if (k == 11) o = 6'h3F;
        else              begin o = 6'h00; f = 6'h21; end
        run_instr(g, o, f);
    endtask

    task automatic lane0;
        run_instr(0, 6'h00, 6'h20);                 // ADD
        run_instr(0, 6'h23, 6'h15);                 // LW, 8 cycles
        repeat (25) run_rand(0, 1'b0);              // counter wraps 15 -> 0
        run_instr(0, 6'h3F, 6'h00);                 // illegal: HALT for 100 cycles
    endtask

    task automatic lane1;
        run_instr(1, 6'h00, 6'h20);                 // ADD
        run_instr(1, 6'h23, 6'h00);                 // LW, 5 cycles
        run_instr(1, 6'h04, 6'h3F);                 // BEQ
        run_instr(1, 6'h00, 6'h00);                 // SLL
        run_instr(1, 6'h3F, 6'h00);                 // illegal as NOP
        repeat (30) run_rand(1, 1'b1);
    endtask

    task automatic lane2;
        int n;
        out_t z;
        z = '0;
        opc_l[2] = 6'h2B; func_l[2] = 6'h00;
        issue(2, 6'h2B, 6'h00, n);
        repeat (3) begin @(posedge clk); #1; end    // now in first MEM cycle
        @(negedge clk); #2;
        exp_q[2].delete();
        rst_l[2] = 1'b0;
        #1 chk("rst_async", 2, obs[2], z);
        mcount[2] = 0;
        @(negedge clk); #1 chk("rst_hold", 2, obs[2], z);
        @(posedge clk); #1 rst_l[2] = 1'b1;
        run_instr(2, 6'h2B, 6'h09);                 // SW, 3 WriteMem cycles
        run_instr(2, 6'h00, 6'h20);
        repeat (10) run_rand(2, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        out_t z;
        z = '0;
        for (int g = 0; g < 3; g++) begin
            rst_l[g] = 1'b0; opc_l[g] = 6'h00; func_l[g] = 6'h20; mcount[g] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) chk("reset", g, obs[g], z);
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) rst_l[g] = 1'b1;
        fork
            lane0();
            lane1();
            lane2();
        join
        @(negedge clk); #1;
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            if (exp_q[g].size() != 0) begin
                n_fail++;
                $display("FAIL drain lane%0d: %0d expected cycles left, required 0", g, exp_q[g].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
